uart_tx_fifo_drain: RTL
=======================

Name: uart_tx_fifo_drain

Overview:
- Consumer on the read side of the byte FIFO: pops one word at a time and serialises it onto the UART TX line as an 8N1-style frame (start, DATA_WIDTH data bits LSB first, one stop bit).
- Sits between the TX FIFO and the board TX pin.
- Continuous back-to-back frames while the FIFO is non-empty; line idles high otherwise.

Parameters:
DATA_WIDTH, 8, word width; must match the FIFO's DATA_WIDTH
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DATA_WIDTH  FIFO read data
fifo_valid  input  1  FIFO read-data valid; high the cycle after an accepted rd_en
fifo_rd_en  output  1  FIFO read enable (combinational, see Behaviour)
tx  output  1  serial line, idle high (registered)
busy  output  1  high in every state except IDLE (registered state decode)
tx_done  output  1  one-cycle pulse at end of stop bit (registered)

Behaviour:
- Reset: synchronous, active-high, one clk. Reset takes priority over all activity, including mid-frame. Resulting state: state=IDLE, tx=1, tx_done=0, baud counter=0, bit index=0, shift register=0, busy=0. A frame interrupted by rst is abandoned; the line returns high on the next edge.
- fifo_rd_en = (state==IDLE) && !fifo_empty && !rst. Combinational, so it is never high for more than one cycle per word.
- IDLE:
  - tx=1.
  - If fifo_rd_en, go to WAIT next edge.
- WAIT (1 cycle):
  - If fifo_valid, latch fifo_dout into the shift register, clear the baud counter and go to START.
  - Else go back to IDLE (defensive; no frame is emitted).
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles per bit.
  - At the end of each bit: shift right; bit index +1.
  - After bit DATA_WIDTH-1 ends, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle assert tx_done for one cycle, coinciding with the transition to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1; the bit boundary is when count==CLKS_PER_BIT-1, after which count wraps to 0.
  - No drift: each bit is exactly CLKS_PER_BIT cycles.
- Bit index width: $clog2(DATA_WIDTH).
- Timing:
  - tx is registered, so the start bit appears on the edge entering START. The first-pop-to-start latency is 2 cycles after fifo_rd_en is high.
  - Frame length is exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
  - Inter-frame gap with a non-empty FIFO is exactly 2 cycles of tx=1 (IDLE + WAIT) beyond the stop bit.
- Boundaries:
  - FIFO goes empty mid-frame: no effect; the frame completes and the block stays in IDLE.
  - Writes to the FIFO during a frame have no effect until IDLE.
  - fifo_rd_en never asserts while fifo_empty=1, so the FIFO is never underflowed.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, WAIT, START, DATA, STOP; 3-bit encoding);
  - CLKS_PER_BIT default;
  - DATA_WIDTH default;
  - the localparams for counter widths.
- One natural sub-module: uart_baud_tick. It holds the counter with synchronous clear and emits bit_end when count==CLKS_PER_BIT-1. The FSM, shift register and bit index stay in the top.

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=8, real FIFO instance as source):
- Reset then idle, FIFO empty, 100 cycles -> tx=1, busy=0, fifo_rd_en=0, tx_done=0 throughout.
- Write 0xA5 once -> fifo_rd_en high for 1 cycle; tx low 2 cycles later for 4 cycles; data bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop high 4 cycles; tx_done single pulse at cycle 40 of the frame; busy high for 41 cycles (WAIT+frame).
- Write 0x00, 0xFF, 0x3C back-to-back -> three frames decoded by bench monitor in order; exactly 2 idle-high cycles between consecutive stop and start bits; FIFO empty after third pop.
- Assert rst for 1 cycle in the middle of data bit 3 of 0x81 -> tx=1 next edge, busy=0, no tx_done. The next FIFO word is sent as a complete, correct frame.
- Force fifo_valid=0 during WAIT (bench override) -> return to IDLE, tx stays 1, no tx_done, no frame emitted.
- Fill the FIFO to 256 entries, drain fully -> 256 frames matching the write order; fifo_rd_en count = 256; never asserted while fifo_empty=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART TX FIFO drain block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_DATA_WIDTH   = 8;

  // Never returns zero so a degenerate count of 1 still gets a 1-bit register.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_BAUD_CW = cnt_width(DEF_CLKS_PER_BIT);
  localparam int DEF_IDX_W   = cnt_width(DEF_DATA_WIDTH);

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CW           = cnt_width(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_end
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_bit_end = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops words from the TX FIFO and serialises each as start / LSB-first data / stop.
//   state | meaning
//   IDLE  | line high, pop when FIFO non-empty
//   WAIT  | one cycle for FIFO read data, abandon if not valid
//   START | start bit (low)
//   DATA  | data bits, LSB first
//   STOP  | stop bit (high), tx_done on its last cycle
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_valid,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int            IW       = cnt_width(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  uart_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_idx;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_bit_end;
  logic                  w_baud_en;
  logic                  w_baud_clr;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  assign w_baud_en   = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign w_baud_clr  = (r_state == WAIT);
  assign w_shift_nxt = r_shift >> 1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_baud_clr),
    .i_en     (w_baud_en),
    .o_bit_end(w_bit_end)
  );

  // Gated by rst so a pop can never be lost to a reset on the same edge.
  assign fifo_rd_en = (r_state == IDLE) && !fifo_empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (fifo_rd_en) begin
            r_state <= WAIT;
            r_busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (fifo_valid) begin
            r_shift <= fifo_dout;
            r_tx    <= 1'b0;
            r_state <= START;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift <= w_shift_nxt;
            r_idx   <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx <= w_shift_nxt[0];
            end
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_done;

endmodule
